// File: rtl/ram_pkg.sv
// Shared definitions for the nibble-bus RAM controller.
// Contents:
//   state_e          - controller state (sweep in progress / serving the bus)
//   *_DEF            - default geometry constants
//   addr_in_range()  - true when an address maps onto a physical word
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;

    // Addresses at or above the depth have no backing word and must not alias.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/ram_bus_driver.sv
// Read-data register and bus driver for the nibble-bus RAM.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   load_i          - a read was accepted on this edge
//   rd_data_i       - word to present on the bus in the following cycle
//   write_enable_i  - host write strobe; releases the bus while high
//   data_bus        - shared bidirectional bus
//   rd_valid_o      - high for the one cycle the bus carries read data
module ram_bus_driver
    import ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              write_enable_i,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              rd_valid_o
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              drive_q;
    logic              rd_valid_q;

    // Next read data: hold the last word unless a new read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (load_i) begin
            rd_data_d = rd_data_i;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Drive window and valid flag last exactly one cycle per accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            drive_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            drive_q    <= load_i;
            rd_valid_q <= load_i;
        end
    end

    // A host write during the drive cycle releases the bus immediately.
    assign data_bus   = (drive_q && !write_enable_i) ? rd_data_q : {DATA_W{1'bz}};
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/ram_nibble_bus_ctrl.sv
// Single-port RAM on a shared bidirectional bus with a hardware clear sweep.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   address        - word address, sampled on the rising edge
//   data_bus       - shared bus: captured on write, driven for one cycle after a read
//   write_enable   - write strobe (wins over read_enable)
//   read_enable    - read strobe
//   clear_req      - request a sweep writing INIT_VAL to every word
//   ready          - block accepts reads and writes
//   rd_valid       - data_bus carries read data this cycle
module ram_nibble_bus_ctrl
    import ram_pkg::*;
#(
    parameter int                DATA_W         = DATA_W_DEF,
    parameter int                ADDR_W         = ADDR_W_DEF,
    parameter int                DEPTH          = DEPTH_DEF,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic              clear_req,
    output logic              ready,
    output logic              rd_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range_s;
    logic              accept_s;
    logic              clear_go_s;
    logic              wr_go_s;
    logic              rd_go_s;
    logic [DATA_W-1:0] rd_word_s;

    // Request decode; only an asserted ready lets the host touch the array.
    always_comb begin
        in_range_s = addr_in_range(32'(address), 32'(DEPTH));
        accept_s   = ready_q && (state_q == ST_IDLE);
        clear_go_s = accept_s && clear_req;
        wr_go_s    = accept_s && write_enable && in_range_s;
        // Write wins a collision; a read coinciding with a clear is dropped.
        rd_go_s    = accept_s && read_enable && !write_enable && !clear_req;
        if (in_range_s) begin
            rd_word_s = mem[address];
        end else begin
            rd_word_s = '0;
        end
    end

    // Next-state logic for the sweep/serve controller.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                ready_d = 1'b0;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (clear_go_s) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    ready_d   = 1'b0;
                end else begin
                    // ready follows the state by one edge so it rises one cycle after the last sweep write.
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Storage array: sweep writes take precedence; contents are never reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= INIT_VAL;
        end else if (wr_go_s) begin
            mem[address] <= data_bus;
        end
    end

    ram_bus_driver #(
        .DATA_W (DATA_W)
    ) u_bus_driver (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (rd_go_s),
        .rd_data_i      (rd_word_s),
        .write_enable_i (write_enable),
        .data_bus       (data_bus),
        .rd_valid_o     (rd_valid)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_ram_nibble_bus_ctrl.sv
// Scoreboard bench: two instances (DEPTH 256 and DEPTH 200) share stimulus;
// reads push expected words into per-instance queues, a negedge monitor pops
// and compares whenever rd_valid is high, and checks bus release otherwise.
module tb_ram_nibble_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic       we, re, clr;
    logic       tb_drv;
    logic [3:0] tb_wdata;
    wire  [3:0] bus_a, bus_b;
    logic       ready_a, ready_b, rdv_a, rdv_b;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] ma[256];
    logic [3:0] mb[200];
    logic [3:0] ea, eb;

    always #5 clk = ~clk;

    assign bus_a = tb_drv ? tb_wdata : 4'bzzzz;
    assign bus_b = tb_drv ? tb_wdata : 4'bzzzz;

    // Undriven bus reads as all ones.
    for (genvar i = 0; i < 4; i++) begin : g_pu
        pullup (bus_a[i]);
        pullup (bus_b[i]);
    end

    ram_nibble_bus_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .address(addr), .data_bus(bus_a),
        .write_enable(we), .read_enable(re), .clear_req(clr),
        .ready(ready_a), .rd_valid(rdv_a)
    );

    ram_nibble_bus_ctrl #(.DEPTH(200)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .address(addr), .data_bus(bus_b),
        .write_enable(we), .read_enable(re), .clear_req(clr),
        .ready(ready_b), .rd_valid(rdv_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare read data, guard release, and idle bus release.
    always @(negedge clk) begin
        if (rdv_a) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected_rd_valid: got 1 expected 0 at %0t", $time);
            end else begin
                ea = qa.pop_front();
                if (we) check("a_write_guard", 32'(bus_a), 32'(tb_wdata));
                else    check("a_read_data", 32'(bus_a), 32'(ea));
            end
        end else if (!tb_drv) begin
            check("a_bus_released", 32'(bus_a), 32'hF);
        end
        if (rdv_b) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected_rd_valid: got 1 expected 0 at %0t", $time);
            end else begin
                eb = qb.pop_front();
                if (we) check("b_write_guard", 32'(bus_b), 32'(tb_wdata));
                else    check("b_read_data", 32'(bus_b), 32'(eb));
            end
        end else if (!tb_drv) begin
            check("b_bus_released", 32'(bus_b), 32'hF);
        end
    end

    // One bus cycle with both instances ready; updates the reference model.
    task automatic op(input logic w, input logic r, input logic [7:0] a, input logic [3:0] d);
        we = w; re = r; addr = a; clr = 1'b0; tb_drv = w; tb_wdata = d;
        if (w) begin
            ma[a] = d;
            if (a < 8'd200) mb[a] = d;
        end else if (r) begin
            qa.push_back(ma[a]);
            qb.push_back((a < 8'd200) ? mb[a] : 4'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 256; i++) ma[i] = 4'h0;
        for (int i = 0; i < 200; i++) mb[i] = 4'h0;
    endtask

    // Count edges until each instance raises ready; optional strobe noise while sweeping.
    task automatic count_ready(input int exp_a, input int exp_b, input bit noise);
        int na, nb;
        na = 0; nb = 0;
        for (int n = 1; n <= 600 && (na == 0 || nb == 0); n++) begin
            if (noise && !ready_a && !ready_b) begin
                we = 1'($urandom); re = 1'($urandom); clr = 1'($urandom);
                addr = 8'($urandom); tb_wdata = 4'($urandom); tb_drv = we;
            end else begin
                we = 1'b0; re = 1'b0; clr = 1'b0; tb_drv = 1'b0;
            end
            @(posedge clk); #1;
            if (na == 0 && ready_a) na = n;
            if (nb == 0 && ready_b) nb = n;
        end
        check("a_ready_latency", 32'(na), 32'(exp_a));
        check("b_ready_latency", 32'(nb), 32'(exp_b));
    endtask

    task automatic random_ops(input int cnt);
        int k;
        for (int i = 0; i < cnt; i++) begin
            k = int'($urandom_range(0, 3));
            op((k == 0) || (k == 2), (k == 1) || (k == 2), 8'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; addr = 8'h00; we = 1'b0; re = 1'b0; clr = 1'b0;
        tb_drv = 1'b0; tb_wdata = 4'h0;
        zero_model();
        #23;
        check("a_ready_in_reset", 32'(ready_a), 32'h0);
        check("b_rd_valid_in_reset", 32'(rdv_b), 32'h0);
        rst_n = 1'b1;
        count_ready(257, 201, 1'b1);

        // Write then read back.
        op(1'b1, 1'b0, 8'h0A, 4'hA);
        op(1'b0, 1'b1, 8'h0A, 4'h0);
        idle(); idle();
        // Back-to-back reads.
        op(1'b1, 1'b0, 8'h10, 4'h5);
        op(1'b1, 1'b0, 8'h11, 4'h3);
        op(1'b0, 1'b1, 8'h10, 4'h0);
        op(1'b0, 1'b1, 8'h11, 4'h0);
        idle(); idle();
        // Simultaneous strobes: write wins.
        op(1'b1, 1'b1, 8'h20, 4'h7);
        idle();
        op(1'b0, 1'b1, 8'h20, 4'h0);
        idle();
        // Out of range on the 200-deep instance, no aliasing.
        op(1'b1, 1'b0, 8'h70, 4'hC);
        op(1'b1, 1'b0, 8'hF0, 4'h9);
        op(1'b0, 1'b1, 8'hF0, 4'h0);
        op(1'b0, 1'b1, 8'h70, 4'h0);
        idle();
        // Host write during the drive cycle releases the bus.
        op(1'b0, 1'b1, 8'h10, 4'h0);
        op(1'b1, 1'b0, 8'h30, 4'h6);
        idle();

        random_ops(400);
        idle(); idle();

        // Clear request with a read on the same edge (read dropped).
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, 8'(a), 4'hF);
        we = 1'b0; re = 1'b1; clr = 1'b1; addr = 8'h05; tb_drv = 1'b0;
        @(posedge clk); #1;
        zero_model();
        count_ready(257, 201, 1'b1);
        op(1'b0, 1'b1, 8'h05, 4'h0);
        op(1'b0, 1'b1, 8'h0F, 4'h0);
        idle(); idle();

        // Reset in the middle of a sweep restarts it from scratch.
        op(1'b1, 1'b0, 8'h44, 4'hB);
        we = 1'b0; re = 1'b0; clr = 1'b1; tb_drv = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        zero_model();
        repeat (100) begin
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        count_ready(257, 201, 1'b0);
        op(1'b0, 1'b1, 8'h44, 4'h0);
        random_ops(60);
        idle(); idle(); idle();

        check("a_queue_drained", 32'(qa.size()), 32'h0);
        check("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_nibble_bus_ctrl.md
Name: ram_nibble_bus_ctrl

Overview:
Parametrised successor to the 4-bit x 256-nibble RAM. It is a single-port RAM on a shared bidirectional data bus, with a registered read and a one-cycle bus-drive window. It adds a hardware clear sequencer that zero-fills the array after reset or on request, and a ready/rd_valid handshake to the CPU datapath. It sits between the HC4 core's address/data bus and the data storage.

Parameters:
DATA_W, 4, data word width in bits (nibble by default)
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
CLEAR_ON_RESET, 1, 1 = run the clear sweep automatically when reset is released; 0 = enter IDLE directly
INIT_VAL, 0, value written to every word during a clear sweep

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
address  input  ADDR_W  word address, sampled on the rising edge
data_bus  inout  DATA_W  shared bus; captured on write, driven by the block only during its read-drive window, else Z
write_enable  input  1  write strobe, sampled on the rising edge
read_enable  input  1  read strobe, sampled on the rising edge
clear_req  input  1  single-cycle request to zero-fill the whole array
ready  output  1  high when the block accepts reads and writes (IDLE state)
rd_valid  output  1  high for exactly the one cycle in which data_bus carries read data

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE
  - clr_cnt = 0, ready = 0, rd_valid = 0, drive = 0, rd_data = 0, so data_bus = Z
  - Array contents are not reset directly; only the sweep initialises them.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes mem[clr_cnt] <= INIT_VAL, then clr_cnt++.
  - After mem[DEPTH-1] is written, move to IDLE. ready rises on the next edge, exactly DEPTH cycles after entering CLEAR.
  - write_enable, read_enable and clear_req are ignored: no array change, no bus drive.
- IDLE, ready = 1:
  - Write: write_enable=1 at the edge -> mem[address] <= data_bus. No latency to the array.
  - Read: read_enable=1 and write_enable=0 at the edge -> rd_data <= mem[address], drive <= 1, rd_valid <= 1.
  - The bus is driven during the following cycle only; drive and rd_valid clear at the next edge unless a new read is accepted.
  - Back-to-back reads keep drive high continuously, and rd_data updates every cycle.
  - clear_req=1 at the edge -> CLEAR with clr_cnt = 0. A read accepted on that same edge is dropped and drive is forced to 0. A write on that same edge is performed, then overwritten by the sweep.
- Simultaneous write_enable and read_enable: the write wins, the read is discarded, and rd_valid stays 0.
- Bus contention guard: data_bus = (drive && !write_enable) ? rd_data : Z. If the host asserts write_enable during a drive cycle, the block releases the bus combinationally.
- Read-after-write: a read of the same address on the edge after the write returns the new value.
- Out of range (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are dropped.
  - Reads return 0 with normal rd_valid timing.
  - No aliasing or wrap.
- clr_cnt width is ADDR_W; its terminal compare is against DEPTH-1, so wrap-around never occurs.
- Reset mid-sweep: the sweep restarts from address 0 after rst_n rises, and a full DEPTH cycles are needed before ready.

Decomposition:
- Shared package ram_pkg:
  - state typedef {ST_CLEAR, ST_IDLE}
  - default constants DATA_W_DEF = 4, ADDR_W_DEF = 8, DEPTH_DEF = 256
- One sub-module: ram_bus_driver. It contains the rd_data/drive/rd_valid registers and the tristate assign with the write guard.
- Array, FSM and sweep counter stay in the top level.

Test Plan:
- Reset release with defaults -> ready = 0 for 256 cycles, ready = 1 on the 257th edge, data_bus = Z throughout, rd_valid = 0.
- After ready: write 4'hA to 8'h0A, then read 8'h0A on the next edge -> in the following cycle data_bus = 4'hA and rd_valid = 1. One cycle later: Z and rd_valid = 0.
- Write 4'h5 to 8'h10 and 4'h3 to 8'h11, then back-to-back reads -> bus shows 5 then 3 on consecutive cycles, rd_valid high for 2 cycles.
- write_enable and read_enable both high at 8'h20 with bus 4'h7 -> bus stays Z, rd_valid = 0. A subsequent read returns 4'h7.
- Fill 8'h00..8'h0F with 4'hF, pulse clear_req -> ready low for 256 cycles. Then read 8'h05 -> 4'h0. Pulse rst_n low at sweep cycle 100 -> ready only after a fresh 256 cycles.
- DEPTH = 200: write 4'h9 to 8'hF0, read 8'hF0 -> 4'h0 with rd_valid = 1. Read 8'h70 is unchanged, so there is no aliasing.
